dmem_access_ctrl: RTL and testbench

- Load/store initiator between the datapath and the byte-addressed, big-endian 16-bit data memory.
- Accepts one load or store request at a time over a valid/ready handshake and drives the memory's address, write-data, read-enable, write-enable and byte-store strobes.
- Waits a configurable read latency, extracts and extends byte loads, and returns a response over a second valid/ready handshake.

---
 rtl/dmem_access_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Load/store initiator sitting between the datapath and a byte-addressed,
// big-endian 16-bit data memory. One request is in flight at a time:
//   IDLE  -> accept a request (req_valid & req_ready)
//   READ  -> hold mem_read for RD_LAT cycles, then sample mem_rdata
//   WRITE -> one-cycle mem_write pulse (byte or word)
//   RESP  -> present the response until rsp_ready is seen
//
// Parameters:
//   RD_LAT      cycles mem_read is held before mem_rdata is sampled (1..15)
//   ALIGN_CHECK 1 = word access at an odd address is answered with rsp_err
//               and never reaches memory; 0 = passed through unchanged
//
// Ports:
//   clk, rst                 clock (posedge), synchronous active-high reset
//   req_valid / req_ready    request handshake (req_ready is combinational)
//   req_op                   00 LW, 01 LB, 10 SW, 11 SB
//   req_signed               LB only: 1 = sign-extend, 0 = zero-extend
//   req_addr, req_wdata      byte address, store data (SB uses [7:0])
//   rsp_valid / rsp_ready    response handshake
//   rsp_data, rsp_err        load result (0 for stores/errors), misalign flag
//   mem_addr, mem_wdata      memory address / write data (held until next accept)
//   mem_read, mem_write      memory strobes (never both high)
//   mem_str_byte             1 = byte store of mem_wdata[7:0]
//   mem_rdata                {M[addr], M[addr+1]}
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int RD_LAT      = 1,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_str_byte,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter value reached in the last mem_read cycle.
  localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        byte_reg, byte_next;       // captured op[0]: byte access
  logic        signed_reg, signed_next;
  logic [15:0] mem_addr_reg, mem_addr_next;
  logic [15:0] mem_wdata_reg, mem_wdata_next;
  logic        mem_read_reg, mem_read_next;
  logic        mem_write_reg, mem_write_next;
  logic        str_byte_reg, str_byte_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_err_reg, rsp_err_next;
  logic [15:0] rsp_data_reg, rsp_data_next;

  logic accept;
  logic misaligned;

  // Big-endian: the byte at the requested address is the upper half of the
  // returned word.
  function automatic logic [15:0] extract_load(input logic is_byte,
                                               input logic sext,
                                               input logic [15:0] rdata);
    logic [15:0] result;
    logic [7:0]  b;
    b = rdata[15:8];
    if (!is_byte) begin
      result = rdata;
    end else if (sext) begin
      result = {{8{b[7]}}, b};
    end else begin
      result = {8'h00, b};
    end
    return result;
  endfunction

  assign req_ready  = (state_reg == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  // Word ops have op[0] == 0.
  assign misaligned = ALIGN_CHECK && !req_op[0] && req_addr[0];

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    byte_next      = byte_reg;
    signed_next    = signed_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_read_next  = mem_read_reg;
    mem_write_next = mem_write_reg;
    str_byte_next  = str_byte_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_err_next   = rsp_err_reg;
    rsp_data_next  = rsp_data_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          byte_next      = req_op[0];
          signed_next    = req_signed;
          mem_addr_next  = req_addr;
          mem_wdata_next = req_wdata;
          cnt_next       = 4'd0;
          if (misaligned) begin
            // Rejected before touching memory.
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_data_next  = 16'h0000;
          end else if (req_op[1]) begin
            state_next     = WRITE;
            mem_write_next = 1'b1;
            str_byte_next  = req_op[0];
          end else begin
            state_next     = READ;
            mem_read_next  = 1'b1;
          end
        end
      end

      READ: begin
        if (cnt_reg == LAT_LAST) begin
          // Edge ending the RD_LAT-th mem_read cycle: data is valid now.
          state_next     = RESP;
          mem_read_next  = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b0;
          rsp_data_next  = extract_load(byte_reg, signed_reg, mem_rdata);
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end

      WRITE: begin
        state_next     = RESP;
        mem_write_next = 1'b0;
        str_byte_next  = 1'b0;
        rsp_valid_next = 1'b1;
        rsp_err_next   = 1'b0;
        rsp_data_next  = 16'h0000;
      end

      RESP: begin
        if (rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
          rsp_err_next   = 1'b0;
          rsp_data_next  = 16'h0000;
        end
      end

      default: begin
        state_next     = IDLE;
        mem_read_next  = 1'b0;
        mem_write_next = 1'b0;
        str_byte_next  = 1'b0;
        rsp_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      byte_reg      <= 1'b0;
      signed_reg    <= 1'b0;
      mem_addr_reg  <= 16'h0000;
      mem_wdata_reg <= 16'h0000;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      str_byte_reg  <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      byte_reg      <= byte_next;
      signed_reg    <= signed_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_read_reg  <= mem_read_next;
      mem_write_reg <= mem_write_next;
      str_byte_reg  <= str_byte_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_data_reg  <= rsp_data_next;
    end
  end

  assign rsp_valid    = rsp_valid_reg;
  assign rsp_data     = rsp_data_reg;
  assign rsp_err      = rsp_err_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign mem_read     = mem_read_reg;
  assign mem_write    = mem_write_reg;
  assign mem_str_byte = str_byte_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Two instances: inst 0 (RD_LAT=1, ALIGN_CHECK=1) and inst 1 (RD_LAT=3,
// ALIGN_CHECK=0), each with its own byte memory model. A monitor keeps a
// transaction-level model (reference memory image plus the cycle schedule
// implied by accept time and op type) and checks every output each cycle.
// Each directed request also carries a hand-computed literal result.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst;
  logic              load_img;
  logic [1:0]        req_valid;
  logic [1:0][1:0]   req_op;
  logic [1:0]        req_signed;
  logic [1:0][15:0]  req_addr;
  logic [1:0][15:0]  req_wdata;
  logic [1:0]        rsp_ready;
  logic [1:0][15:0]  mem_rdata;

  wire  [1:0]        req_ready;
  wire  [1:0]        rsp_valid;
  wire  [1:0][15:0]  rsp_data;
  wire  [1:0]        rsp_err;
  wire  [1:0][15:0]  mem_addr;
  wire  [1:0][15:0]  mem_wdata;
  wire  [1:0]        mem_read;
  wire  [1:0]        mem_write;
  wire  [1:0]        mem_str_byte;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic ac_of(input int i);
    return (i == 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [7:0] img_byte(input int k);
    logic [7:0] b;
    case (k)
      0: b = 8'h31;  1: b = 8'h42;  2: b = 8'h00;  3: b = 8'h00;
      4: b = 8'h56;  5: b = 8'h78;  6: b = 8'hDE;  7: b = 8'hAD;
      8: b = 8'hBE;  9: b = 8'hEF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    dmem_access_ctrl #(
      .RD_LAT      ((gi == 0) ? 1 : 3),
      .ALIGN_CHECK ((gi == 0) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk          (clk),
      .rst          (rst[gi]),
      .req_valid    (req_valid[gi]),
      .req_ready    (req_ready[gi]),
      .req_op       (req_op[gi]),
      .req_signed   (req_signed[gi]),
      .req_addr     (req_addr[gi]),
      .req_wdata    (req_wdata[gi]),
      .rsp_valid    (rsp_valid[gi]),
      .rsp_ready    (rsp_ready[gi]),
      .rsp_data     (rsp_data[gi]),
      .rsp_err      (rsp_err[gi]),
      .mem_addr     (mem_addr[gi]),
      .mem_wdata    (mem_wdata[gi]),
      .mem_read     (mem_read[gi]),
      .mem_write    (mem_write[gi]),
      .mem_str_byte (mem_str_byte[gi]),
      .mem_rdata    (mem_rdata[gi])
    );

    // Byte memory (16 bytes, address wraps). Read data is only valid in the
    // RD_LAT-th consecutive mem_read cycle; otherwise a poison pattern.
    logic [7:0] mem [0:15];
    logic [3:0] rd_cnt;
    logic [3:0] ma;
    assign ma = mem_addr[gi][3:0];
    assign mem_rdata[gi] = (mem_read[gi] && (int'(rd_cnt) == lat_of(gi) - 1))
                           ? {mem[ma], mem[ma + 4'd1]} : 16'hA5A5;

    always @(posedge clk) begin
      if (load_img) begin
        for (int k = 0; k < 16; k++) mem[k] <= img_byte(k);
      end else if (mem_write[gi]) begin
        if (mem_str_byte[gi]) begin
          mem[ma] <= mem_wdata[gi][7:0];
        end else begin
          mem[ma]        <= mem_wdata[gi][15:8];
          mem[ma + 4'd1] <= mem_wdata[gi][7:0];
        end
      end
      rd_cnt <= (mem_read[gi] && !rst[gi]) ? rd_cnt + 4'd1 : 4'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / model
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] lit_data [2];
  logic        lit_err  [2];

  logic [7:0]  ref_mem  [2][16];
  logic        started  [2] = '{1'b0, 1'b0};
  logic        act      [2] = '{1'b0, 1'b0};
  logic        fresh    [2] = '{1'b0, 1'b0};
  int          acc_cyc  [2];
  int          first_k  [2];
  logic        e_load   [2];
  logic        e_store  [2];
  logic        e_strb   [2];
  logic [15:0] e_addr   [2];
  logic [15:0] e_wdata  [2];
  logic [15:0] e_data   [2];
  logic        e_err    [2];

  int          kk;
  logic [3:0]  ai;
  logic [15:0] word;
  logic [7:0]  bt;

  task automatic chk(input string name, input int i,
                     input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst %0d cycle %0d got %h want %h", name, i, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (load_img) begin
        for (int k = 0; k < 16; k++) ref_mem[i][k] = img_byte(k);
      end

      if (started[i]) begin
        chk("req_ready", i, 16'(req_ready[i]), 16'(!act[i] && !rst[i]));
        if (!act[i]) begin
          chk("idle_rsp_valid", i, 16'(rsp_valid[i]), 16'h0);
          chk("idle_mem_read",  i, 16'(mem_read[i]),  16'h0);
          chk("idle_mem_write", i, 16'(mem_write[i]), 16'h0);
          if (fresh[i]) begin
            chk("rst_mem_addr",  i, mem_addr[i],  16'h0000);
            chk("rst_mem_wdata", i, mem_wdata[i], 16'h0000);
            chk("rst_rsp_data",  i, rsp_data[i],  16'h0000);
            chk("rst_rsp_err",   i, 16'(rsp_err[i]),      16'h0);
            chk("rst_str_byte",  i, 16'(mem_str_byte[i]), 16'h0);
          end
        end else begin
          kk = cyc - acc_cyc[i];
          chk("mem_addr",  i, mem_addr[i],  e_addr[i]);
          chk("mem_wdata", i, mem_wdata[i], e_wdata[i]);
          chk("mem_read",  i, 16'(mem_read[i]),
              16'(e_load[i] && kk >= 1 && kk <= lat_of(i)));
          chk("mem_write", i, 16'(mem_write[i]), 16'(e_store[i] && kk == 1));
          if (e_store[i] && kk == 1)
            chk("str_byte", i, 16'(mem_str_byte[i]), 16'(e_strb[i]));
          chk("rsp_valid", i, 16'(rsp_valid[i]), 16'(kk >= first_k[i]));
          if (kk >= first_k[i]) begin
            chk("rsp_data", i, rsp_data[i], e_data[i]);
            chk("rsp_err",  i, 16'(rsp_err[i]), 16'(e_err[i]));
          end
          if (kk == first_k[i]) begin
            chk("lit_data", i, rsp_data[i], lit_data[i]);
            chk("lit_err",  i, 16'(rsp_err[i]), 16'(lit_err[i]));
          end
        end
      end

      if (rst[i]) begin
        started[i] = 1'b1;
        act[i]     = 1'b0;
        fresh[i]   = 1'b1;
      end else if (started[i] && req_valid[i] && req_ready[i]) begin
        act[i]     = 1'b1;
        fresh[i]   = 1'b0;
        acc_cyc[i] = cyc;
        e_addr[i]  = req_addr[i];
        e_wdata[i] = req_wdata[i];
        e_load[i]  = 1'b0;
        e_store[i] = 1'b0;
        e_strb[i]  = 1'b0;
        e_err[i]   = 1'b0;
        e_data[i]  = 16'h0000;
        ai = req_addr[i][3:0];
        if (ac_of(i) && !req_op[i][0] && req_addr[i][0]) begin
          first_k[i] = 1;
          e_err[i]   = 1'b1;
        end else if (req_op[i][1]) begin
          e_store[i] = 1'b1;
          e_strb[i]  = req_op[i][0];
          first_k[i] = 2;
          if (req_op[i][0]) begin
            ref_mem[i][ai] = req_wdata[i][7:0];
          end else begin
            ref_mem[i][ai]        = req_wdata[i][15:8];
            ref_mem[i][ai + 4'd1] = req_wdata[i][7:0];
          end
        end else begin
          e_load[i]  = 1'b1;
          first_k[i] = lat_of(i) + 1;
          word = {ref_mem[i][ai], ref_mem[i][ai + 4'd1]};
          bt   = word[15:8];
          if (!req_op[i][0])      e_data[i] = word;
          else if (req_signed[i]) e_data[i] = {{8{bt[7]}}, bt};
          else                    e_data[i] = {8'h00, bt};
        end
      end else if (act[i] && rsp_valid[i] && rsp_ready[i]) begin
        act[i] = 1'b0;
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic issue(input int i, input logic [1:0] op, input logic sg,
                       input logic [15:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp_d, input logic exp_e,
                       input int hold);
    bit ok;
    lit_data[i]   = exp_d;
    lit_err[i]    = exp_e;
    req_op[i]     = op;
    req_signed[i] = sg;
    req_addr[i]   = addr;
    req_wdata[i]  = wd;
    req_valid[i]  = 1'b1;
    rsp_ready[i]  = (hold == 0);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      $display("FAIL accept_timeout inst %0d got req_ready 0 want 1", i);
      $fatal(1);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    if (hold > 0) begin
      // Offer a competing request while the response is being held off.
      req_valid[i] = 1'b1;
      req_op[i]    = 2'b11;
      req_addr[i]  = 16'h0003;
      req_wdata[i] = 16'h00FF;
      repeat (hold) begin @(posedge clk); #1; end
      req_valid[i] = 1'b0;
      rsp_ready[i] = 1'b1;
    end
  endtask

  task automatic finish_rsp(input int i);
    bit ok;
    logic [15:0] d;
    logic e;
    ok = 1'b0;
    d = 16'h0;
    e = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp_valid[i] && rsp_ready[i]) begin
        ok = 1'b1; d = rsp_data[i]; e = rsp_err[i]; break;
      end
    end
    if (!ok) begin
      $display("FAIL rsp_timeout inst %0d got rsp_valid 0 want 1", i);
      $fatal(1);
    end
    @(posedge clk); #1;
    $display("txn inst %0d op %0d addr %h wdata %h -> data %h err %0d (expect %h %0d)",
             i, req_op[i], req_addr[i], req_wdata[i], d, e, lit_data[i], lit_err[i]);
  endtask

  task automatic do_req(input int i, input logic [1:0] op, input logic sg,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_d, input logic exp_e,
                        input int hold);
    issue(i, op, sg, addr, wd, exp_d, exp_e, hold);
    finish_rsp(i);
  endtask

  localparam logic [1:0] LW = 2'b00, LB = 2'b01, SW = 2'b10, SB = 2'b11;

  initial begin
    rst        = 2'b11;
    load_img   = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_signed = '0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 2'b11;
    lit_data   = '{16'h0, 16'h0};
    lit_err    = '{1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    rst      = 2'b00;
    load_img = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Instance 0: RD_LAT=1, ALIGN_CHECK=1
    do_req(0, LW, 1'b0, 16'h0004, 16'h0000, 16'h5678, 1'b0, 0);
    do_req(0, LB, 1'b1, 16'h0006, 16'h0000, 16'hFFDE, 1'b0, 0);
    do_req(0, LB, 1'b0, 16'h0006, 16'h0000, 16'h00DE, 1'b0, 0);
    do_req(0, LB, 1'b1, 16'h0001, 16'h0000, 16'h0042, 1'b0, 0);
    do_req(0, SW, 1'b0, 16'h0002, 16'hCAFE, 16'h0000, 1'b0, 0);
    do_req(0, LW, 1'b0, 16'h0002, 16'h0000, 16'hCAFE, 1'b0, 0);
    do_req(0, SB, 1'b0, 16'h0009, 16'h1234, 16'h0000, 1'b0, 0);
    do_req(0, LW, 1'b0, 16'h0008, 16'h0000, 16'hBE34, 1'b0, 0);
    do_req(0, LW, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b1, 0);
    do_req(0, SW, 1'b0, 16'h0003, 16'hBEEF, 16'h0000, 1'b1, 0);
    do_req(0, LW, 1'b0, 16'h0002, 16'h0000, 16'hCAFE, 1'b0, 0);

    // Instance 1: RD_LAT=3, ALIGN_CHECK=0
    do_req(1, LW, 1'b0, 16'h0005, 16'h0000, 16'h78DE, 1'b0, 0);
    do_req(1, LW, 1'b0, 16'h0000, 16'h0000, 16'h3142, 1'b0, 7);
    do_req(1, LB, 1'b0, 16'h0007, 16'h0000, 16'h00AD, 1'b0, 0);

    // Reset in the middle of a READ: the response must never appear.
    issue(1, LW, 1'b0, 16'h0000, 16'h0000, 16'h3142, 1'b0, 0);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    do_req(1, LW, 1'b0, 16'h0008, 16'h0000, 16'hBEEF, 1'b0, 0);

    repeat (3) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
